// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory byte loader.
package loader_pkg;
  localparam int IMEM_AW = 10;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } loader_state_t;
endpackage

// File: rtl/loader_timeout_ctr.sv
// loader_timeout_ctr: down-counter that flags expiry after TIMEOUT_CYCLES-1 idle run cycles.
module loader_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clear ? LOAD : (run && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    expired = run && !clear && cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= LOAD;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/imem_byte_loader.sv
// imem_byte_loader: parses a word-count header, packs little-endian bytes into
// 32-bit instruction words and holds the core in reset until the load completes.
module imem_byte_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int IMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               write_en,
  output logic [IMEM_AW-1:0] write_addr,
  output logic [31:0]        write_data,
  output logic               rst_im,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code,
  output logic [IMEM_AW:0]   words_loaded
);
  loader_state_t state_q, state_d;
  logic [1:0] err_q, err_d, bidx_q, bidx_d;
  logic [IMEM_AW:0] wl_q, wl_d, count_q, count_d, wl_inc;
  logic [7:0] lo_q, lo_d;
  logic [23:0] pack_q, pack_d;
  logic [31:0] data_q, data_d;
  logic [15:0] len;
  logic xfer, expired;
  assign in_ready = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA};
  assign xfer = in_valid && in_ready;
  assign write_en = state_q == S_WRITE;
  assign write_addr = wl_q[IMEM_AW-1:0];
  assign write_data = data_q;
  assign rst_im = state_q == S_CLEAR;
  assign core_hold = state_q != S_DONE;
  assign load_done = state_q == S_DONE;
  assign load_err = state_q == S_ERR;
  assign err_code = err_q;
  assign words_loaded = wl_q;
  loader_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clear(rst_im || xfer),
    .run(in_ready && !in_valid),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    bidx_d = bidx_q;
    wl_d = wl_q;
    count_d = count_q;
    lo_d = lo_q;
    pack_d = pack_q;
    data_d = data_q;
    len = {in_data, lo_q};
    wl_inc = wl_q + 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: state_d = load_start ? S_CLEAR : state_q;
      S_CLEAR: begin
        wl_d = '0;
        bidx_d = '0;
        err_d = ERR_NONE;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        lo_d = xfer ? in_data : lo_q;
        state_d = xfer ? S_LEN_HI : expired ? S_ERR : state_q;
        err_d = (!xfer && expired) ? ERR_TIMEOUT : err_q;
      end
      S_LEN_HI: begin
        if (xfer) begin
          count_d = len[IMEM_AW:0];
          state_d = (len == 16'd0 || len > 16'(IMEM_WORDS)) ? S_ERR : S_DATA;
          err_d = (state_d == S_ERR) ? ERR_LEN : err_q;
        end else if (expired) begin
          state_d = S_ERR;
          err_d = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (xfer) begin
          pack_d = {in_data, pack_q[23:8]};
          bidx_d = bidx_q + 1'b1;
          data_d = (bidx_q == 2'd3) ? {in_data, pack_q} : data_q;
          state_d = (bidx_q == 2'd3) ? S_WRITE : S_DATA;
        end else if (expired) begin
          state_d = S_ERR;
          err_d = ERR_TIMEOUT;
        end
      end
      S_WRITE: begin
        wl_d = wl_inc;
        state_d = (wl_inc == count_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      err_q <= ERR_NONE;
      bidx_q <= '0;
      wl_q <= '0;
      count_q <= '0;
      lo_q <= '0;
      pack_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      bidx_q <= bidx_d;
      wl_q <= wl_d;
      count_q <= count_d;
      lo_q <= lo_d;
      pack_q <= pack_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_imem_byte_loader.sv
// tb_imem_byte_loader: scoreboard bench for the instruction-memory byte loader.
module tb_imem_byte_loader;
  logic clk = 0, rst = 0, load_start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, write_en, rst_im, core_hold, load_done, load_err;
  logic [9:0] write_addr;
  logic [31:0] write_data;
  logic [1:0] err_code;
  logic [10:0] words_loaded;
  int n_err = 0, n_chk = 0, cyc = 0, last_tx = 0, nwr = 0, nrim = 0;
  logic [9:0] last_addr = 0;
  logic [41:0] sb[$];
  imem_byte_loader #(.TIMEOUT_CYCLES(16), .IMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data), .rst_im(rst_im),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .err_code(err_code), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_im) nrim++;
    if (write_en) begin
      if (sb.size() == 0) chk("unexp_wr", {write_addr, write_data}, 0);
      else chk("wr", {write_addr, write_data}, sb.pop_front());
      chk("rdy_in_wr", in_ready, 0);
      nwr++;
      last_addr = write_addr;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap, n;
    gap = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_data = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      chk("rdy_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    last_tx = cyc;
  endtask
  task automatic send_word(input logic [9:0] a, input logic [31:0] d, input int maxgap);
    sb.push_back({a, d});
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], maxgap);
  endtask
  task automatic start_load();
    @(posedge clk);
    #1 load_start = 1;
    @(posedge clk);
    #1 load_start = 0;
    chk("rst_im_t1", rst_im, 1);
    chk("rdy_t1", in_ready, 0);
    @(posedge clk);
    #1 chk("rdy_t2", in_ready, 1);
  endtask
  task automatic wait_end();
    int n = 0;
    in_valid = 0;
    while (!(load_done || load_err) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("end_seen", load_done || load_err, 1);
  endtask
  initial begin
    int w0, r0, dt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", core_hold, 1);
    chk("rst_outs", {in_ready, write_en, rst_im, load_done, load_err, err_code}, 0);
    chk("rst_regs", {write_addr, write_data, words_loaded}, 0);
    rst = 1;
    // basic two-word load with in_valid held high
    r0 = nrim;
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(10'd0, 32'hDEADBEEF, 0);
    send_word(10'd1, 32'h00000013, 0);
    chk("b_wr_en", write_en, 1);
    chk("b_hold_wr", core_hold, 1);
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("b_hold_fall", core_hold, 0);
    chk("b_done", {load_done, load_err, write_en}, 3'b100);
    chk("b_words", words_loaded, 2);
    chk("b_rim", nrim - r0, 1);
    // bad lengths: zero and IMEM_WORDS+1
    w0 = nwr;
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    in_valid = 0;
    chk("l0_err", {load_err, err_code, core_hold, load_done}, {1'b1, 2'd1, 1'b1, 1'b0});
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    in_valid = 0;
    chk("l1025_err", {load_err, err_code, core_hold}, {1'b1, 2'd1, 1'b1});
    chk("len_nowr", nwr - w0, 0);
    // timeout after partial word
    start_load();
    chk("tmo_clr", {load_err, err_code}, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    wait_end();
    dt = cyc - last_tx;
    chk("tmo_delay", dt, 16);
    chk("tmo_code", {load_err, err_code, core_hold}, {1'b1, 2'd2, 1'b1});
    chk("tmo_nowr", nwr - w0, 0);
    // full-depth load with random gaps
    w0 = nwr;
    start_load();
    send_byte(8'h00, 3);
    send_byte(8'h04, 3);
    for (int i = 0; i < 1024; i++) send_word(10'(i), $urandom, 3);
    wait_end();
    chk("full_done", {load_done, load_err}, 2'b10);
    chk("full_words", words_loaded, 1024);
    chk("full_nwr", nwr - w0, 1024);
    chk("full_last", last_addr, 1023);
    chk("full_sb", sb.size(), 0);
    // reset in the middle of a load, then a fresh one-word load
    start_load();
    send_byte(8'h0A, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_word(10'(i), $urandom, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 0;
    rst = 0;
    @(posedge clk);
    #1;
    chk("mr_hold", core_hold, 1);
    chk("mr_outs", {in_ready, write_en, load_done, load_err}, 0);
    chk("mr_words", words_loaded, 0);
    chk("mr_sb", sb.size(), 0);
    rst = 1;
    w0 = nwr;
    repeat (4) @(posedge clk);
    #1 chk("mr_nowr", nwr - w0, 0);
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(10'd0, 32'h12345678, 0);
    wait_end();
    chk("mr_done", {load_done, words_loaded}, {1'b1, 11'd1});
    // load_start during DATA is ignored
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    sb.push_back({10'd0, 32'hCAFEF00D});
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    in_valid = 0;
    r0 = nrim;
    load_start = 1;
    @(posedge clk);
    #1 load_start = 0;
    @(posedge clk);
    #1;
    chk("ign_rim", nrim - r0, 0);
    chk("ign_rdy", in_ready, 1);
    send_byte(8'hFE, 0);
    send_byte(8'hCA, 0);
    send_word(10'd1, 32'h0BADC0DE, 2);
    wait_end();
    chk("ign_done", {load_done, words_loaded}, {1'b1, 11'd2});
    chk("end_sb", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
